// File: rtl/zbt_video_pkg.sv
// Shared constants for the ZBT video path: word/pixel/address widths,
// XGA 1024x768 timing defaults and the frame reader state encoding.
package zbt_video_pkg;

   localparam int ZBT_DATA_W = 36;
   localparam int PIXEL_W    = 18;
   localparam int ZBT_ADDR_W = 19;

   // XGA 1024x768 @ 60 Hz, 65 MHz pixel clock
   localparam int XGA_H_ACTIVE = 1024;
   localparam int XGA_H_TOTAL  = 1344;
   localparam int XGA_V_ACTIVE = 768;
   localparam int XGA_V_TOTAL  = 806;

   localparam logic [0:0] WAIT_FRAME = 1'b0;
   localparam logic [0:0] RUN        = 1'b1;

   // Pick one 18-bit pixel out of a ZBT word: even x in the high half.
   function automatic logic [PIXEL_W-1:0] zbt_pixel_half(
      input logic [ZBT_DATA_W-1:0] word,
      input logic                  odd
   );
      return odd ? word[PIXEL_W-1:0] : word[ZBT_DATA_W-1:PIXEL_W];
   endfunction

endpackage

// File: rtl/zbt_read_tag_pipe.sv
// Delay line that follows each issued ZBT read through the fixed read
// latency; its output strobes when that read's data is on the bus.
module zbt_read_tag_pipe #(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic rd_issued,
   output logic capture
);

   logic [DEPTH-1:0] tag_q;
   logic [DEPTH-1:0] tag_d;

   // Shift the read tag one stage per clock.
   always_comb begin
      tag_d    = tag_q;
      tag_d[0] = rd_issued;
      for (int i = 1; i < DEPTH; i++) begin
         tag_d[i] = tag_q[i-1];
      end
   end

   // Tag register; reset discards reads still in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tag_q <= '0;
      end else begin
         tag_q <= tag_d;
      end
   end

   assign capture = tag_q[DEPTH-1];

endmodule

// File: rtl/zbt_frame_reader.sv
// ZBT frame reader: prefetches pixel words from ZBT SRAM ahead of the XGA
// raster and presents one registered pixel per clock aligned to hcount/vcount.
// Optional build macro ZBT_READER_ZOOM_EN: 2x zoom of the 512x384 top-left
// region (each stored pixel shown as a 2x2 block).
//
// state      | meaning
// -----------+-----------------------------------------------------------
// WAIT_FRAME | after reset; no reads, no pixels, waiting for the first
//            | prefetch point of a frame (hcount=H_TOTAL-FORECAST, last line)
// RUN        | synced to the raster; issues reads and outputs pixels
module zbt_frame_reader
   import zbt_video_pkg::*;
#(
   parameter int H_ACTIVE = XGA_H_ACTIVE,
   parameter int V_ACTIVE = XGA_V_ACTIVE,
   parameter int H_TOTAL  = XGA_H_TOTAL,
   parameter int V_TOTAL  = XGA_V_TOTAL,
   parameter int READ_LAT = 2,
   parameter int FORECAST = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [10:0]           hcount,
   input  logic [9:0]            vcount,
   input  logic [ZBT_DATA_W-1:0] vram_read_data,
   output logic [ZBT_ADDR_W-1:0] vram_addr,
   output logic                  vram_rd,
   output logic [PIXEL_W-1:0]    pixel,
   output logic                  pixel_valid
);

   logic [0:0]            state_q, state_d;
   logic [ZBT_ADDR_W-1:0] vram_addr_q, vram_addr_d;
   logic                  vram_rd_q, vram_rd_d;
   logic [ZBT_DATA_W-1:0] word_latch_q, word_latch_d;
   logic [PIXEL_W-1:0]    pixel_q, pixel_d;
   logic                  pixel_valid_q, pixel_valid_d;

   logic [11:0] fh_sum;
   logic [11:0] fh;
   logic [10:0] fv;
   logic        sync_hit;
   logic        reading;
   logic        rd_slot;
   logic        capture;
   logic        active;
   logic        odd_sel;

   // Forecast coordinates: where the raster will be FORECAST pixels from now.
   always_comb begin
      fh_sum = {1'b0, hcount} + 12'(FORECAST);
      fh     = fh_sum;
      fv     = {1'b0, vcount};
      if (fh_sum >= 12'(H_TOTAL)) begin
         fh = fh_sum - 12'(H_TOTAL);
         fv = {1'b0, vcount} + 11'd1;
      end
      if (fv == 11'(V_TOTAL)) begin
         fv = '0;
      end
   end

   // Sync detection and state update.
   always_comb begin
      sync_hit = (state_q == WAIT_FRAME) &&
                 (hcount == 11'(H_TOTAL - FORECAST)) &&
                 (vcount == 10'(V_TOTAL - 1));
      state_d  = state_q;
      if (sync_hit) begin
         state_d = RUN;
      end
      // The sync cycle itself is the prefetch point for pixel 0 of frame 0.
      reading = (state_q == RUN) || sync_hit;
   end

   // Read issue: one read per ZBT word whose first pixel is the forecast pixel.
   always_comb begin
`ifdef ZBT_READER_ZOOM_EN
      rd_slot = (fh < 12'(H_ACTIVE)) && (fv < 11'(V_ACTIVE)) && (fh[1:0] == 2'b00);
`else
      rd_slot = (fh < 12'(H_ACTIVE)) && (fv < 11'(V_ACTIVE)) && (fh[0] == 1'b0);
`endif
      vram_addr_d = vram_addr_q;
      vram_rd_d   = 1'b0;
      if (reading && rd_slot) begin
`ifdef ZBT_READER_ZOOM_EN
         vram_addr_d = {1'b0, fv[9:1], 1'b0, fh[9:2]};
`else
         vram_addr_d = {fv[9:0], fh[9:1]};
`endif
         vram_rd_d   = 1'b1;
      end
   end

   zbt_read_tag_pipe #(
      .DEPTH (READ_LAT)
   ) u_tag_pipe (
      .clk       (clk),
      .reset     (reset),
      .rd_issued (vram_rd_q),
      .capture   (capture)
   );

   // Word latch and pixel select; the latch may reload on the same edge that
   // consumes its last half, since pixel_d reads the old value.
   always_comb begin
      word_latch_d = capture ? vram_read_data : word_latch_q;
      active       = (state_q == RUN) &&
                     (hcount < 11'(H_ACTIVE)) && (vcount < 10'(V_ACTIVE));
`ifdef ZBT_READER_ZOOM_EN
      odd_sel      = hcount[1];
`else
      odd_sel      = hcount[0];
`endif
      pixel_d       = active ? zbt_pixel_half(word_latch_q, odd_sel) : '0;
      pixel_valid_d = active;
   end

   // All state registers; reset clears outputs immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= WAIT_FRAME;
         vram_addr_q   <= '0;
         vram_rd_q     <= 1'b0;
         word_latch_q  <= '0;
         pixel_q       <= '0;
         pixel_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         vram_addr_q   <= vram_addr_d;
         vram_rd_q     <= vram_rd_d;
         word_latch_q  <= word_latch_d;
         pixel_q       <= pixel_d;
         pixel_valid_q <= pixel_valid_d;
      end
   end

   assign vram_addr   = vram_addr_q;
   assign vram_rd     = vram_rd_q;
   assign pixel       = pixel_q;
   assign pixel_valid = pixel_valid_q;

endmodule

// File: tb/tb_zbt_frame_reader.sv
// Scoreboard bench for zbt_frame_reader: the raster driver pushes expected
// reads and pixels, a monitor pops them whenever the DUT strobes vram_rd or
// pixel_valid. Honours ZBT_READER_ZOOM_EN the same way as the design.
module tb_zbt_frame_reader;

   localparam int H_ACTIVE = 1024;
   localparam int V_ACTIVE = 768;
   localparam int H_TOTAL  = 1344;
   localparam int V_TOTAL  = 806;
   localparam int FORECAST = 4;

`ifdef ZBT_READER_ZOOM_EN
   localparam int          RD_STEP  = 4;
   localparam int          CNT_LAST = 4;
   localparam logic [18:0] A_WRAP0  = 19'h00800;
   localparam logic [18:0] A_4_6    = 19'h00602;
   localparam logic [17:0] P_10_5   = 18'h3FBFD;
   localparam logic [17:0] P_11_5   = 18'h3FBFD;
   localparam logic [17:0] P_8_6    = 18'h00602;
   localparam logic [17:0] P_9_6    = 18'h00602;
   localparam logic [17:0] P_8_7    = 18'h00602;
   localparam logic [17:0] P_9_7    = 18'h00602;
   localparam logic [17:0] P_0_8    = 18'h00800;
`else
   localparam int          RD_STEP  = 2;
   localparam int          CNT_LAST = 9;
   localparam logic [18:0] A_WRAP0  = 19'h01000;
   localparam logic [18:0] A_WRAP1  = 19'h01001;
   localparam logic [18:0] A_4_6    = 19'h00C04;
   localparam logic [17:0] P_10_5   = 18'h00A05;
   localparam logic [17:0] P_11_5   = 18'h3F5FA;
   localparam logic [17:0] P_8_6    = 18'h00C04;
   localparam logic [17:0] P_9_6    = 18'h3F3FB;
   localparam logic [17:0] P_8_7    = 18'h00E04;
   localparam logic [17:0] P_9_7    = 18'h3F1FB;
   localparam logic [17:0] P_0_8    = 18'h01000;
`endif

   typedef struct {
      logic [18:0] addr;
      int          h;
      int          v;
   } rd_exp_t;

   typedef struct {
      logic [17:0] pix;
      int          h;
      int          v;
   } pix_exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [10:0] hcount;
   logic [9:0]  vcount;
   logic [35:0] vram_read_data;
   logic [18:0] vram_addr;
   logic        vram_rd;
   logic [17:0] pixel;
   logic        pixel_valid;

   rd_exp_t  exp_rd_q[$];
   pix_exp_t exp_pix_q[$];
   logic     synced_m = 1'b0;
   int       rd_cnt[1024];
   int       checks = 0;
   int       errors = 0;

   zbt_frame_reader dut (
      .clk            (clk),
      .reset          (reset),
      .hcount         (hcount),
      .vcount         (vcount),
      .vram_read_data (vram_read_data),
      .vram_addr      (vram_addr),
      .vram_rd        (vram_rd),
      .pixel          (pixel),
      .pixel_valid    (pixel_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [35:0] act, input logic [35:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   function automatic logic [18:0] word_addr(input int x, input int y);
      logic [10:0] xx;
      logic [9:0]  yy;
      xx = x[10:0];
      yy = y[9:0];
`ifdef ZBT_READER_ZOOM_EN
      return {1'b0, yy[9:1], 1'b0, xx[9:2]};
`else
      return {yy, xx[9:1]};
`endif
   endfunction

   function automatic logic [17:0] model_pixel(input int x, input int y);
      logic [18:0] a;
      logic        odd;
      a = word_addr(x, y);
`ifdef ZBT_READER_ZOOM_EN
      odd = ((x / 2) % 2) == 1;
`else
      odd = (x % 2) == 1;
`endif
      return odd ? ~a[17:0] : a[17:0];
   endfunction

   task automatic push_expect(input int h, input int v);
      int       fh, fv;
      logic     hit;
      rd_exp_t  r;
      pix_exp_t p;
      fh = h + FORECAST;
      fv = v;
      if (fh >= H_TOTAL) begin
         fh = fh - H_TOTAL;
         fv = v + 1;
      end
      if (fv == V_TOTAL) fv = 0;
      hit = !synced_m && (h == H_TOTAL - FORECAST) && (v == V_TOTAL - 1);
      if ((synced_m || hit) && fh < H_ACTIVE && fv < V_ACTIVE && (fh % RD_STEP) == 0) begin
         r.addr = word_addr(fh, fv);
         r.h = h;
         r.v = v;
         exp_rd_q.push_back(r);
      end
      if (synced_m && h < H_ACTIVE && v < V_ACTIVE) begin
         p.pix = model_pixel(h, v);
         p.h = h;
         p.v = v;
         exp_pix_q.push_back(p);
      end
      if (hit) synced_m = 1'b1;
   endtask

   task automatic drive_cycle(input int h, input int v, input logic rst_in);
      @(negedge clk);
      reset  = rst_in;
      hcount = h[10:0];
      vcount = v[9:0];
      if (rst_in) begin
         exp_rd_q.delete();
         exp_pix_q.delete();
         synced_m = 1'b0;
      end else begin
         push_expect(h, v);
      end
   endtask

   task automatic drive_line(input int v, input int h0, input int h1);
      for (int h = h0; h <= h1; h++) drive_cycle(h, v, 1'b0);
   endtask

   // ZBT model: word {addr[17:0], ~addr[17:0]}, two cycles after the address.
   initial begin
      logic [18:0] a1, a2;
      a1 = '0;
      a2 = '0;
      vram_read_data = '0;
      forever begin
         @(negedge clk);
         vram_read_data = {a2[17:0], ~a2[17:0]};
         a2 = a1;
         a1 = vram_addr;
      end
   end

   // Monitor: compare every strobed output against the scoreboard.
   initial begin
      rd_exp_t  r;
      pix_exp_t p;
      forever begin
         @(posedge clk);
         #1;
         if (vram_rd === 1'b1) begin
            rd_cnt[vram_addr[18:9]]++;
            if (exp_rd_q.size() == 0) begin
               check("rd_unexpected", {35'd0, vram_rd}, 36'd0);
            end else begin
               r = exp_rd_q.pop_front();
               check($sformatf("rd_addr h=%0d v=%0d", r.h, r.v), {17'd0, vram_addr}, {17'd0, r.addr});
               if (r.h == 1340 && r.v == 805) check("first_addr", {17'd0, vram_addr}, 36'd0);
               if (r.h == 1340 && r.v == 7)   check("wrap_addr0", {17'd0, vram_addr}, {17'd0, A_WRAP0});
`ifndef ZBT_READER_ZOOM_EN
               if (r.h == 1342 && r.v == 7)   check("wrap_addr1", {17'd0, vram_addr}, {17'd0, A_WRAP1});
`endif
               if (r.h == 4 && r.v == 6)      check("addr_8_6", {17'd0, vram_addr}, {17'd0, A_4_6});
            end
         end
         if (pixel_valid === 1'b1) begin
            if (exp_pix_q.size() == 0) begin
               check("pix_unexpected", {35'd0, pixel_valid}, 36'd0);
            end else begin
               p = exp_pix_q.pop_front();
               check($sformatf("pixel h=%0d v=%0d", p.h, p.v), {18'd0, pixel}, {18'd0, p.pix});
               if (p.h == 10 && p.v == 5) check("pix_10_5", {18'd0, pixel}, {18'd0, P_10_5});
               if (p.h == 11 && p.v == 5) check("pix_11_5", {18'd0, pixel}, {18'd0, P_11_5});
               if (p.h == 8  && p.v == 6) check("pix_8_6",  {18'd0, pixel}, {18'd0, P_8_6});
               if (p.h == 9  && p.v == 6) check("pix_9_6",  {18'd0, pixel}, {18'd0, P_9_6});
               if (p.h == 8  && p.v == 7) check("pix_8_7",  {18'd0, pixel}, {18'd0, P_8_7});
               if (p.h == 9  && p.v == 7) check("pix_9_7",  {18'd0, pixel}, {18'd0, P_9_7});
               if (p.h == 0  && p.v == 8) check("pix_0_8",  {18'd0, pixel}, {18'd0, P_0_8});
            end
         end else begin
            check("pixel_blank", {18'd0, pixel}, 36'd0);
         end
      end
   end

   // Raster driver.
   initial begin
      for (int i = 0; i < 1024; i++) rd_cnt[i] = 0;
      reset  = 1'b1;
      hcount = '0;
      vcount = 10'd400;
      repeat (2) @(negedge clk);
      #1;
      check("reset_addr",  {17'd0, vram_addr}, 36'd0);
      check("reset_rd",    {35'd0, vram_rd}, 36'd0);
      check("reset_pixel", {18'd0, pixel}, 36'd0);
      check("reset_valid", {35'd0, pixel_valid}, 36'd0);

      // Reset held 3 cycles mid-frame, then run into frame 0.
      for (int h = 0; h < H_TOTAL; h++) drive_cycle(h, 400, h < 3);
      drive_line(401, 0, H_TOTAL - 1);
      drive_line(804, 0, H_TOTAL - 1);
      drive_line(805, 0, H_TOTAL - 1);
      for (int v = 0; v <= 9; v++) drive_line(v, 0, H_TOTAL - 1);
      for (int i = 0; i <= CNT_LAST; i++) check($sformatf("reads_per_line idx=%0d", i), 36'(rd_cnt[i]), 36'd512);

      // End of active area, vertical blanking, frame wrap.
      drive_line(766, 1200, H_TOTAL - 1);
      drive_line(767, 0, H_TOTAL - 1);
      drive_line(768, 0, H_TOTAL - 1);
      drive_line(805, 0, H_TOTAL - 1);
      drive_line(0, 0, H_TOTAL - 1);
      for (int i = 768; i < 1024; i++) check($sformatf("blank_reads idx=%0d", i), 36'(rd_cnt[i]), 36'd0);

      // Reset mid-line at (600, 100), then resync on the next frame.
      drive_line(99, 1200, H_TOTAL - 1);
      drive_line(100, 0, 599);
      drive_cycle(600, 100, 1'b1);
      #1;
      check("midreset_addr",  {17'd0, vram_addr}, 36'd0);
      check("midreset_rd",    {35'd0, vram_rd}, 36'd0);
      check("midreset_pixel", {18'd0, pixel}, 36'd0);
      check("midreset_valid", {35'd0, pixel_valid}, 36'd0);
      drive_cycle(601, 100, 1'b1);
      drive_cycle(602, 100, 1'b1);
      drive_line(100, 603, H_TOTAL - 1);
      drive_line(101, 0, H_TOTAL - 1);
      drive_line(805, 0, H_TOTAL - 1);
      drive_line(0, 0, H_TOTAL - 1);
      drive_line(1, 0, H_TOTAL - 1);
      drive_line(2, 1100, 1107);

      check("rd_queue_drained",  36'(exp_rd_q.size()), 36'd0);
      check("pix_queue_drained", 36'(exp_pix_q.size()), 36'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
